// File: rtl/fp32_pkg.sv
// Shared constants, FSM state encoding and the binary32 result layout for the normalize/pack block.
package fp32_pkg;

    localparam int unsigned BIAS       = 127;
    localparam int unsigned EXP_MAX    = 255;
    localparam int unsigned EXP_ENC_W  = 8;
    localparam int unsigned FRAC_W     = 23;
    localparam int unsigned EXP_W_DEF  = 10;
    localparam int unsigned MANT_W_DEF = 28;
    localparam int unsigned HID_POS    = 25;
    localparam int          UFLOW_EXP  = -25;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_ENC_W-1:0] exp;
        logic [FRAC_W-1:0]    frac;
    } fp32_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Combinational round-to-nearest-even of a normalized magnitude (hidden bit, fraction, guard, sticky).
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [HID_POS:0]  i_mant,
    output logic [FRAC_W-1:0] o_frac_c,
    output logic              o_hidden_c,
    output logic              o_carry_c,
    output logic              o_inexact_c
);

    logic                w_up;
    logic [HID_POS-1:0]  w_sum;

    // Adding one at the fraction LSB is the same as adding 4 to the raw magnitude.
    assign w_up        = i_mant[1] & (i_mant[0] | i_mant[2]);
    assign w_sum       = {1'b0, i_mant[HID_POS:2]} + HID_POS'(w_up);
    assign o_carry_c   = w_sum[HID_POS-1];
    assign o_hidden_c  = w_sum[HID_POS-2] | o_carry_c;
    assign o_frac_c    = w_sum[FRAC_W-1:0];
    assign o_inexact_c = i_mant[1] | i_mant[0];

endmodule

// File: rtl/fp32_normalize_pack.sv
// Iterative normalizer: shifts one bit per cycle, rounds RNE, packs IEEE-754 binary32 with overflow/inexact flags.
module fp32_normalize_pack
    import fp32_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned MANT_W = MANT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic              io_sign,
    input  logic [EXP_W-1:0]  io_exp,
    input  logic [MANT_W-1:0] io_mantissa,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [31:0]       io_fpNumber,
    output logic              io_overflow,
    output logic              io_inexact
);

    // Two extra exponent bits so right shifts and rounding carry never wrap.
    localparam int unsigned XW  = EXP_W + 2;
    localparam int unsigned HID = MANT_W - 3;

    state_t                r_state;
    logic                  r_sign;
    logic signed [XW-1:0]  r_exp;
    logic [MANT_W-1:0]     r_mant;
    logic [31:0]           r_fp;
    logic                  r_ovf;
    logic                  r_inx;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic signed [XW-1:0]  w_exp_in;
    logic signed [XW-1:0]  w_exp_rnd;
    logic                  w_underflow;
    logic                  w_shr;
    logic                  w_shl;
    logic                  w_ovf;
    logic [FRAC_W-1:0]     w_frac;
    logic                  w_hidden;
    logic                  w_carry;
    logic                  w_inexact;
    fp32_t                 w_res;

    fp32_round_rne u_round (
        .i_mant      (r_mant[HID:0]),
        .o_frac_c    (w_frac),
        .o_hidden_c  (w_hidden),
        .o_carry_c   (w_carry),
        .o_inexact_c (w_inexact)
    );

    assign w_exp_in    = XW'($signed(io_exp));
    assign w_underflow = w_exp_in <= $signed(XW'(UFLOW_EXP));
    assign w_shr       = (|r_mant[MANT_W-1:MANT_W-2]) || (r_exp < $signed(XW'(1)));
    assign w_shl       = !r_mant[HID] && (r_exp > $signed(XW'(1)));
    assign w_exp_rnd   = w_carry ? r_exp + $signed(XW'(1)) : r_exp;
    assign w_ovf       = w_exp_rnd >= $signed(XW'(EXP_MAX));

    // Pack: subnormals (no hidden bit after rounding) encode exponent 0; overflow saturates to infinity.
    always_comb begin
        w_res      = '0;
        w_res.sign = r_sign;
        if (w_ovf) begin
            w_res.exp = '1;
        end else begin
            w_res.exp  = w_hidden ? w_exp_rnd[EXP_ENC_W-1:0] : '0;
            w_res.frac = w_frac;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_fp        <= '0;
            r_ovf       <= 1'b0;
            r_inx       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_in_valid) begin
                        r_sign     <= io_sign;
                        r_exp      <= w_exp_in;
                        r_mant     <= io_mantissa;
                        r_in_ready <= 1'b0;
                        if (io_mantissa == '0 || w_underflow) begin
                            r_fp        <= {io_sign, 31'b0};
                            r_ovf       <= 1'b0;
                            r_inx       <= |io_mantissa;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (w_shr) begin
                        r_mant <= {1'b0, r_mant[MANT_W-1:2], |r_mant[1:0]};
                        r_exp  <= r_exp + $signed(XW'(1));
                    end else if (w_shl) begin
                        r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                        r_exp  <= r_exp - $signed(XW'(1));
                    end else begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_fp        <= w_res;
                    r_ovf       <= w_ovf;
                    r_inx       <= w_ovf | w_inexact;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (io_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_in_ready  = r_in_ready;
    assign io_out_valid = r_out_valid;
    assign io_fpNumber  = r_fp;
    assign io_overflow  = r_ovf;
    assign io_inexact   = r_inx;

endmodule

// File: tb/tb_fp32_normalize_pack.sv
// Directed-vector bench for fp32_normalize_pack: results, flags, latency, backpressure and reset behaviour.
module tb_fp32_normalize_pack;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic        io_sign = 1'b0;
    logic [9:0]  io_exp = '0;
    logic [27:0] io_mantissa = '0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [31:0] io_fpNumber;
    logic        io_overflow;
    logic        io_inexact;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        s;
        int          e;
        logic [27:0] m;
        logic [31:0] fp;
        logic        ovf;
        logic        inx;
        int          lat;
    } vec_t;

    fp32_normalize_pack #(.EXP_W(10), .MANT_W(28)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_sign      (io_sign),
        .io_exp       (io_exp),
        .io_mantissa  (io_mantissa),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_fpNumber  (io_fpNumber),
        .io_overflow  (io_overflow),
        .io_inexact   (io_inexact)
    );

    always #5 clock = ~clock;

    // Drive one operand, measure accept-to-valid latency (accept edge counts as 1), capture, then consume.
    task automatic run_op(input logic s, input int e, input logic [27:0] m,
                          output logic [31:0] fp, output logic ovf, output logic inx, output int lat);
        @(negedge clock);
        io_sign     = s;
        io_exp      = 10'(e);
        io_mantissa = m;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        lat = 1;
        while (!io_out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!io_out_valid) lat = -1;
        fp  = io_fpNumber;
        ovf = io_overflow;
        inx = io_inexact;
        if (io_out_valid) begin
            @(negedge clock);
            io_out_ready = 1'b1;
            @(posedge clock);
            #1;
            io_out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", io_out_valid); end
        n_cmp++; if (io_fpNumber !== 32'h0) begin n_err++; $display("FAIL reset_fp: got %h want 00000000", io_fpNumber); end
        n_cmp++; if ({io_overflow, io_inexact} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {io_overflow, io_inexact}); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++; if (io_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", io_in_ready); end
    endtask

    task automatic test_normalize();
        vec_t v[$];
        logic [31:0] fp; logic ovf, inx; int lat;
        v.push_back('{"one",       1'b0, 127, 28'h2000000, 32'h3F800000, 1'b0, 1'b0, 3});
        v.push_back('{"shl2",      1'b0, 127, 28'h0800000, 32'h3E800000, 1'b0, 1'b0, 5});
        v.push_back('{"shr2_six",  1'b0, 127, 28'hC000000, 32'h40C00000, 1'b0, 1'b0, 5});
        v.push_back('{"neg_three", 1'b1, 128, 28'h3000000, 32'hC0400000, 1'b0, 1'b0, 3});
        v.push_back('{"max_norm",  1'b0, 254, 28'h2000000, 32'h7F000000, 1'b0, 1'b0, 3});
        foreach (v[i]) begin
            run_op(v[i].s, v[i].e, v[i].m, fp, ovf, inx, lat);
            n_cmp++; if ({fp, ovf, inx} !== {v[i].fp, v[i].ovf, v[i].inx}) begin n_err++;
                $display("FAIL %s: got fp=%h ovf=%b inx=%b want fp=%h ovf=%b inx=%b", v[i].name, fp, ovf, inx, v[i].fp, v[i].ovf, v[i].inx); end
            n_cmp++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_rounding();
        vec_t v[$];
        logic [31:0] fp; logic ovf, inx; int lat;
        v.push_back('{"tie_even_down", 1'b0, 127, 28'h2000002, 32'h3F800000, 1'b0, 1'b1, 3});
        v.push_back('{"tie_odd_up",    1'b0, 127, 28'h2000006, 32'h3F800002, 1'b0, 1'b1, 3});
        v.push_back('{"carry_exp",     1'b0, 127, 28'h3FFFFFE, 32'h40000000, 1'b0, 1'b1, 3});
        v.push_back('{"sub_to_norm",   1'b0, 1,   28'h1FFFFFE, 32'h00800000, 1'b0, 1'b1, 3});
        v.push_back('{"sticky_shr",    1'b0, -1,  28'h2000001, 32'h00200000, 1'b0, 1'b1, 5});
        foreach (v[i]) begin
            run_op(v[i].s, v[i].e, v[i].m, fp, ovf, inx, lat);
            n_cmp++; if ({fp, ovf, inx} !== {v[i].fp, v[i].ovf, v[i].inx}) begin n_err++;
                $display("FAIL %s: got fp=%h ovf=%b inx=%b want fp=%h ovf=%b inx=%b", v[i].name, fp, ovf, inx, v[i].fp, v[i].ovf, v[i].inx); end
            n_cmp++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t v[$];
        logic [31:0] fp; logic ovf, inx; int lat;
        v.push_back('{"ovf_shr",      1'b1, 254, 28'h4000000, 32'hFF800000, 1'b1, 1'b1, 4});
        v.push_back('{"ovf_big_exp",  1'b0, 300, 28'h2000000, 32'h7F800000, 1'b1, 1'b1, 3});
        v.push_back('{"subnormal",    1'b0, 1,   28'h1000000, 32'h00400000, 1'b0, 1'b0, 3});
        v.push_back('{"exp0_sub",     1'b0, 0,   28'h2000000, 32'h00400000, 1'b0, 1'b0, 4});
        v.push_back('{"zero",         1'b1, 50,  28'h0000000, 32'h80000000, 1'b0, 1'b0, 1});
        v.push_back('{"uflow_m25",    1'b0, -25, 28'h2000000, 32'h00000000, 1'b0, 1'b1, 1});
        v.push_back('{"edge_m24",     1'b0, -24, 28'h2000000, 32'h00000000, 1'b0, 1'b1, 28});
        foreach (v[i]) begin
            run_op(v[i].s, v[i].e, v[i].m, fp, ovf, inx, lat);
            n_cmp++; if ({fp, ovf, inx} !== {v[i].fp, v[i].ovf, v[i].inx}) begin n_err++;
                $display("FAIL %s: got fp=%h ovf=%b inx=%b want fp=%h ovf=%b inx=%b", v[i].name, fp, ovf, inx, v[i].fp, v[i].ovf, v[i].inx); end
            n_cmp++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        int seen = 0;
        @(negedge clock);
        io_sign = 1'b0; io_exp = 10'd127; io_mantissa = 28'h2000000; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        // Keep offering a different operand while busy; it must be ignored.
        io_mantissa = 28'h3000000;
        while (!io_out_valid && waited < 40) begin
            @(posedge clock);
            #1;
            waited++;
        end
        n_cmp++; if (io_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_timeout: got %b want 1", io_out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            n_cmp++; if ({io_out_valid, io_in_ready, io_fpNumber} !== {1'b1, 1'b0, 32'h3F800000}) begin n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b fp=%h want valid=1 ready=0 fp=3f800000", c, io_out_valid, io_in_ready, io_fpNumber); end
        end
        io_in_valid = 1'b0;
        @(negedge clock);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        n_cmp++; if ({io_out_valid, io_in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", io_out_valid, io_in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (io_out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL bp_no_queue: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fp; logic ovf, inx; int lat;
        run_op(1'b0, 127, 28'h2000000, fp, ovf, inx, lat);
        n_cmp++; if ({io_in_ready, io_out_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_idle: got ready=%b valid=%b want ready=1 valid=0", io_in_ready, io_out_valid); end
        run_op(1'b1, 128, 28'h2000000, fp, ovf, inx, lat);
        n_cmp++; if ({fp, ovf, inx} !== {32'hC0000000, 1'b0, 1'b0}) begin n_err++; $display("FAIL b2b_second: got fp=%h ovf=%b inx=%b want fp=c0000000 ovf=0 inx=0", fp, ovf, inx); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        @(negedge clock);
        io_sign = 1'b0; io_exp = 10'd127; io_mantissa = 28'h0800000; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({io_out_valid, io_in_ready, io_fpNumber} !== {1'b0, 1'b1, 32'h0}) begin n_err++;
            $display("FAIL rst_mid: got valid=%b ready=%b fp=%h want valid=0 ready=1 fp=00000000", io_out_valid, io_in_ready, io_fpNumber); end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (io_out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_discard: got %0d valid cycles want 0", seen); end
        n_cmp++; if (io_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", io_in_ready); end
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_rounding();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
